// File: rtl/iter_div_unit.sv
// iter_div_unit
//   Multi-cycle RISC-V M-extension divide/remainder unit (DIV, DIVU, REM, REMU)
//   built around a radix-2 restoring divider that retires one quotient bit per
//   cycle. Divide-by-zero and signed overflow are resolved in the accept cycle.
//
// Ports
//   clk     system clock, rising-edge
//   rst     synchronous active-low reset
//   start   request a new operation (sampled only in IDLE)
//   op      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A, B    dividend (rs1) and divisor (rs2), sampled with start
//   flush   abort the in-flight operation
//   busy    high while CALC or FIX (pipeline stall)
//   done    one-cycle pulse, result valid while high
//   result  quotient or remainder, held until the next accepted start
module iter_div_unit #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    r_state;
  logic          r_is_rem;
  logic          r_sign_q;
  logic          r_sign_r;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_result;

  logic          w_signed;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [N-1:0]  w_abs_a;
  logic [N-1:0]  w_abs_b;
  logic          w_div0;
  logic          w_ovf;
  logic [N:0]    w_shift;
  logic [N:0]    w_diff;
  logic [N-1:0]  w_quo_fix;
  logic [N-1:0]  w_rem_fix;

  // op[0] clear selects the signed variants (DIV, REM).
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & A[N-1];
  assign w_b_neg  = w_signed & B[N-1];
  // Negating the most negative value yields itself, which is the correct
  // unsigned magnitude, so no special handling is needed here.
  assign w_abs_a  = w_a_neg ? -A : A;
  assign w_abs_b  = w_b_neg ? -B : B;
  assign w_div0   = (B == '0);
  assign w_ovf    = w_signed && (A == MOST_NEG) && (B == '1);

  // Shifted partial remainder is below 2*divisor, so the (N+1)-bit difference
  // never wraps and its MSB is a reliable "would go negative" flag.
  assign w_shift  = {r_rem, r_quo[N-1]};
  assign w_diff   = w_shift - {1'b0, r_div};

  assign w_quo_fix = r_sign_q ? -r_quo : r_quo;
  assign w_rem_fix = r_sign_r ? -r_rem : r_rem;

  assign busy   = (r_state == S_CALC) || (r_state == S_FIX);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_is_rem <= op[1];
            if (w_div0) begin
              r_result <= op[1] ? A : '1;
              r_state  <= S_DONE;
            end else if (w_ovf) begin
              r_result <= op[1] ? '0 : MOST_NEG;
              r_state  <= S_DONE;
            end else begin
              r_sign_q <= w_a_neg ^ w_b_neg;
              r_sign_r <= w_a_neg;
              r_rem    <= '0;
              r_quo    <= w_abs_a;
              r_div    <= w_abs_b;
              r_cnt    <= '0;
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            // Keep the difference when non-negative, otherwise restore.
            r_rem <= w_diff[N] ? w_shift[N-1:0] : w_diff[N-1:0];
            r_quo <= {r_quo[N-2:0], ~w_diff[N]};
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(N-1)) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= r_is_rem ? w_rem_fix : w_quo_fix;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// tb_iter_div_unit
//   Self-checking bench for iter_div_unit: directed vectors, mid-operation
//   flush/reset/start events, and randomized operands against an arithmetic
//   reference model.
module tb_iter_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int errors;

  iter_div_unit #(.N(32), .CW(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RISC-V divide semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (o)
      2'b00: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      2'b01: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      2'b10: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 0;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation from IDLE and waits (bounded) for done.
  // lat = edges after the accepting edge until done is seen; bcnt = busy
  // samples seen before done; dn_after = done one cycle after the pulse.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt,
                        output logic dn_after);
    op = o; A = a; B = b; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
    res = result;
    step();
    dn_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; A = '0; B = '0;
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic [1:0]  ops [12] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd2};
    logic [31:0] as  [12] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'hFFFF_FFFF, 32'd7, 32'd5, 32'd5,
                             32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'd7};
    logic [31:0] bs  [12] = '{32'd3, 32'd3, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] exp [12] = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'd5,
                             32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFD, 32'd1};
    int          elat[12] = '{33, 33, 33, 33, 0, 0, 0, 0, 33, 33, 33, 33};
    logic [31:0] res;
    int lat, bcnt;
    logic dn2;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, bcnt, dn2);
      checks++;
      if (res !== exp[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, exp[i]); end
      checks++;
      if (lat != elat[i]) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, elat[i]); end
      checks++;
      if (bcnt != elat[i]) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bcnt, elat[i]); end
      checks++;
      if (dn2 !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b want 0", i, dn2); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, bcnt, seen;
    logic dn2;
    run_op(2'd1, 32'd100, 32'd7, res, lat, bcnt, dn2);
    checks++;
    if (res !== 32'd14) begin errors++; $display("FAIL flush_setup got %h want %h", res, 32'd14); end
    op = 2'd1; A = 32'd1000; B = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    checks++;
    if (result !== 32'd14) begin errors++; $display("FAIL flush_result got %h want %h", result, 32'd14); end
    seen = 0;
    repeat (40) begin
      if (done) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL flush_no_done got %0d want 0", seen); end
    // flush with start in IDLE: a divide-by-zero request would finish at once if taken
    op = 2'd1; A = 32'd9; B = 32'd0; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_start_idle got done=%b busy=%b want 0 0", done, busy);
    end
    run_op(2'd1, 32'd1000, 32'd3, res, lat, bcnt, dn2);
    checks++;
    if (res !== 32'd333) begin errors++; $display("FAIL flush_after got %h want %h", res, 32'd333); end
    checks++;
    if (lat != 33) begin errors++; $display("FAIL flush_after_latency got %0d want 33", lat); end
  endtask

  task automatic test_reset_mid();
    op = 2'd0; A = 32'hFFFF_FFEC; B = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (32) step();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_fix_state got busy=%b done=%b want 1 0", busy, done);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL rstmid_result got %h want 0", result); end
    rst = 1'b1;
    step();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rstmid_after got done=%b want 0", done); end
  endtask

  task automatic test_start_in_calc();
    int lat;
    op = 2'd2; A = 32'hFFFF_FFEC; B = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    lat = 0;
    repeat (5) begin step(); lat++; end
    op = 2'd1; A = 32'd50; B = 32'd0; start = 1'b1;
    step();
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin step(); lat++; end
    checks++;
    if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL calc_start_result got %h want %h", result, 32'hFFFF_FFFE); end
    checks++;
    if (lat != 33) begin errors++; $display("FAIL calc_start_latency got %0d want 33", lat); end
    step();
  endtask

  task automatic test_done_events();
    // start held through the DONE cycle must not be taken there
    op = 2'd0; A = 32'd5; B = 32'd0; start = 1'b1;
    step();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_pulse got %b want 1", done); end
    op = 2'd1; A = 32'd40; B = 32'd4; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_start_ignored got done=%b busy=%b want 0 0", done, busy);
    end
    checks++;
    if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL done_result got %h want %h", result, 32'hFFFF_FFFF); end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, res, exp;
    logic dn2;
    int lat, bcnt, sel, elat;
    for (int i = 0; i < 1000; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) b = 32'hFFFF_FFFF;
      else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 3) b = 32'($urandom_range(1, 15));
      else if (sel == 4) a = 32'($urandom_range(0, 100));
      exp  = ref_model(o, a, b);
      elat = ref_latency(o, a, b);
      run_op(o, a, b, res, lat, bcnt, dn2);
      checks++;
      if (res !== exp) begin
        errors++; $display("FAIL rand%0d_result op=%0d a=%h b=%h got %h want %h", i, o, a, b, res, exp);
      end
      checks++;
      if (lat != elat) begin
        errors++; $display("FAIL rand%0d_latency op=%0d a=%h b=%h got %0d want %0d", i, o, a, b, lat, elat);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_flush();
    test_reset_mid();
    test_start_in_calc();
    test_done_events();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_div_unit.md
Name: iter_div_unit

Overview:
- Multi-cycle RISC-V M-extension divide/remainder unit in the EX stage, beside the combinational ALU.
- Takes the same rs1/rs2 operands as the ALU and replaces the single-cycle DIV/DIVU/REM/REMU datapath with a radix-2 restoring divider.
- Feeds the EX/MEM result mux and drives a busy signal to the hazard unit so the pipeline stalls until the result is ready.

Parameters:
- N, 32, operand and result width in bits.
- CW, 6, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Equals funct3[1:0] of funct3 100..111.
- A  input  N  dividend (rs1); sampled with start.
- B  input  N  divisor (rs2); sampled with start.
- flush  input  1  abort the in-flight operation (branch mispredict or exception).
- busy  output  1  high in CALC and FIX; the hazard unit stalls IF/ID/EX while busy.
- done  output  1  one-cycle pulse; result is valid while done is high.
- result  output  N  quotient or remainder; held stable until the next start is accepted.

Behaviour:
- Reset: when rst is low at a clock edge, state goes to IDLE and busy=0, done=0, result=0, counter=0. Reset has priority over flush and start in every state, including mid-operation.
- States: IDLE, CALC, FIX, DONE.
- IDLE with start=1: latch op, A and B.
  - Divide-by-zero (B==0): result = all ones for DIV/DIVU, A for REM/REMU; go to DONE.
  - Signed overflow (op=DIV or REM, A==0x8000_0000, B==all ones): result = 0x8000_0000 for DIV, 0 for REM; go to DONE.
  - Otherwise: record sign_q = A[N-1]^B[N-1] and sign_r = A[N-1] for signed ops (0 for unsigned ops). Load |A| and |B| (raw values for unsigned ops), clear the partial remainder, set counter=0, go to CALC.
- CALC, one bit per cycle:
  - Shift {rem, quo} left by 1 and form rem - divisor in an (N+1)-bit subtractor.
  - If the difference is non-negative, keep it and set quo[0]=1; otherwise restore.
  - Increment the counter. After the N-th iteration (counter==N-1 at the edge), go to FIX.
- FIX: apply sign correction.
  - Quotient is negated if sign_q; remainder is negated if sign_r.
  - Register the selected value into result and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE; it must be re-presented in IDLE.
- Latency: with start accepted at edge E0, the normal path puts done high after edge E0+N+1 (N=32 gives 33 edges). Special cases put done high after E0.
- busy is 0 in IDLE and DONE and 1 in CALC and FIX. The hazard unit also stalls combinationally on start && IDLE && op is M-div; that stall is not this block's output.
- start outside IDLE is ignored; the latched operands are unaffected.
- flush in CALC or FIX: go to IDLE at that edge. No done pulse, result unchanged.
- flush in DONE: done still completes its cycle; the consumer discards it.
- flush together with start in IDLE: start is ignored.
- Remainder sign follows the dividend and the quotient truncates toward zero, per RISC-V.
- All operand, counter and result registers hold their value when not updated; there are no latches or combinational loops.

Test Plan:
- DIV: A=-20 (0xFFFF_FFEC), B=3 -> busy for 33 cycles, then one done pulse with result=0xFFFF_FFFA (-6). REM on the same operands -> result=0xFFFF_FFFE (-2).
- DIVU: A=0xFFFF_FFFF, B=2 -> result=0x7FFF_FFFF. REMU: A=7, B=0xFFFF_FFFF -> result=7. Both after 33 cycles.
- Divide-by-zero: DIV A=5, B=0 -> done the cycle after start, busy never high, result=0xFFFF_FFFF. REM A=5, B=0 -> result=5.
- Overflow: DIV A=0x8000_0000, B=0xFFFF_FFFF -> result=0x8000_0000 in 1 cycle. REM on the same operands -> result=0.
- Mid-operation events:
  - flush 10 cycles into CALC -> IDLE next edge, no done, result keeps its prior value, next start works normally.
  - rst=0 during FIX -> busy=0, done=0, result=0 after that edge.
  - start pulsed during CALC -> ignored; the first result is unchanged.
- Back-to-back: start asserted in the cycle right after done -> accepted. Compare 1000 random signed and unsigned operand pairs against a reference model that includes the divide-by-zero and overflow rules.
